iomem_bus_ctrl: RTL and testbench

// - Sequences the picosoc iomem bus and shares it between NUM_SLAVES peripherals, e.g. GPIO and the template peripheral.
// - Decodes addr[31:24] into a one-hot slave select and registers the request towards the slave.
// - Waits for the selected slave's ready; on timeout, completes the access itself with TIMEOUT_DATA.
// - Returns a single-cycle iomem_ready to the SoC.

---
 rtl/iomem_bus_ctrl.sv | 154 +++++++++++++++
 tb/tb_iomem_bus_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/iomem_bus_ctrl.sv
// picosoc iomem bus sequencer: decodes addr[31:24] into a one-hot slave select,
// waits for the slave's ready (or times out) and returns a one-cycle iomem_ready.
module iomem_bus_ctrl #(
    parameter int unsigned NUM_SLAVES   = 4,
    parameter logic [7:0]  BASE_PAGE    = 8'h03,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       iomem_valid,
    output logic                       iomem_ready,
    input  logic [3:0]                 iomem_wstrb,
    input  logic [31:0]                iomem_addr,
    input  logic [31:0]                iomem_wdata,
    output logic [31:0]                iomem_rdata,
    output logic [NUM_SLAVES-1:0]      s_sel,
    output logic [3:0]                 s_wstrb,
    output logic [23:0]                s_addr,
    output logic [31:0]                s_wdata,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    input  logic                       err_clr,
    output logic                       err_flag,
    output logic [31:0]                err_addr
);

    localparam int unsigned IdxW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [31:0]             addr_q, addr_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [TimerW-1:0]       timer_q, timer_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_flag_q, err_flag_d;
    logic [31:0]             err_addr_q, err_addr_d;

    logic [8:0]              page, page_lo, page_hi;
    logic [7:0]              page_off;
    logic                    hit;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;
    logic                    timed_out;

    // 9-bit compare so a window near 8'hFF does not wrap
    assign page     = {1'b0, iomem_addr[31:24]};
    assign page_lo  = {1'b0, BASE_PAGE};
    assign page_hi  = page_lo + 9'(NUM_SLAVES);
    assign hit      = iomem_valid && (page >= page_lo) && (page < page_hi);
    assign page_off = iomem_addr[31:24] - BASE_PAGE;
    assign timed_out = (timer_q == TimerW'(TIMEOUT - 1));

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (idx_q == IdxW'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        timer_d    = timer_q;
        rdata_d    = rdata_q;
        err_flag_d = err_clr ? 1'b0 : err_flag_q;
        err_addr_d = err_addr_q;

        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    idx_d   = page_off[IdxW-1:0];
                    addr_d  = iomem_addr;
                    wstrb_d = iomem_wstrb;
                    wdata_d = iomem_wdata;
                    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
                        sel_d[i] = (page_off == 8'(i));
                    end
                    timer_d = '0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                timer_d = timer_q + 1'b1;
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    sel_d   = '0;
                    state_d = StResp;
                end else if (timed_out) begin
                    rdata_d    = TIMEOUT_DATA;
                    err_flag_d = 1'b1;
                    err_addr_d = addr_q;
                    sel_d      = '0;
                    state_d    = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            addr_q     <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            timer_q    <= '0;
            rdata_q    <= '0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            timer_q    <= timer_d;
            rdata_q    <= rdata_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign iomem_ready = (state_q == StResp);
    assign iomem_rdata = rdata_q;
    assign s_sel       = sel_q;
    assign s_wstrb     = wstrb_q;
    assign s_addr      = addr_q[23:0];
    assign s_wdata     = wdata_q;
    assign err_flag    = err_flag_q;
    assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// Directed bench for iomem_bus_ctrl: expected completions are queued when a request
// is driven and checked when iomem_ready fires.
module tb_iomem_bus_ctrl;

    logic         clk = 1'b0;
    logic         resetn;
    logic         iomem_valid;
    logic         iomem_ready;
    logic [3:0]   iomem_wstrb;
    logic [31:0]  iomem_addr;
    logic [31:0]  iomem_wdata;
    logic [31:0]  iomem_rdata;
    logic [3:0]   s_sel;
    logic [3:0]   s_wstrb;
    logic [23:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready;
    logic         err_clr;
    logic         err_flag;
    logic [31:0]  err_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        logic        err;
    } exp_t;

    exp_t sb[$];

    iomem_bus_ctrl #(
        .NUM_SLAVES   (4),
        .BASE_PAGE    (8'h03),
        .TIMEOUT      (8),
        .TIMEOUT_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .s_sel       (s_sel),
        .s_wstrb     (s_wstrb),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .s_ready     (s_ready),
        .err_clr     (err_clr),
        .err_flag    (err_flag),
        .err_addr    (err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  32'(iomem_ready), 32'h0);
        check({tag, "_rdata"},  iomem_rdata,      32'h0);
        check({tag, "_sel"},    32'(s_sel),       32'h0);
        check({tag, "_swstrb"}, 32'(s_wstrb),     32'h0);
        check({tag, "_saddr"},  32'(s_addr),      32'h0);
        check({tag, "_swdata"}, s_wdata,          32'h0);
        check({tag, "_errf"},   32'(err_flag),    32'h0);
        check({tag, "_erra"},   err_addr,         32'h0);
    endtask

    // k<0: slave never readies. clr_at: cycle on which err_clr is driven (0 = never).
    task automatic access(input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input int slot, input int k,
                          input logic [3:0] noise, input int clr_at,
                          input logic [31:0] exp_rdata, input int exp_lat,
                          input logic exp_err);
        exp_t        e;
        bit          done;
        logic [3:0]  onehot;
        done   = 1'b0;
        onehot = 4'b0001 << slot;
        @(negedge clk);
        e.rdata = exp_rdata;
        e.lat   = exp_lat;
        e.err   = exp_err;
        sb.push_back(e);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge clk);
            if (iomem_ready) begin
                iomem_valid = 1'b0;
                s_ready     = 4'b0;
                err_clr     = 1'b0;
                check("sb_nonempty", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rdata",    iomem_rdata,   e.rdata);
                    check("latency",  32'(n),        32'(e.lat));
                    check("err_flag", 32'(err_flag), 32'(e.err));
                end
                check("sel_cleared", 32'(s_sel), 32'h0);
                done = 1'b1;
            end else begin
                check("s_sel",   32'(s_sel),   32'(onehot));
                check("s_addr",  32'(s_addr),  32'(addr[23:0]));
                check("s_wstrb", 32'(s_wstrb), 32'(wstrb));
                check("s_wdata", s_wdata,      wdata);
                s_ready = noise | ((k >= 0 && n == k + 1) ? onehot : 4'b0);
                err_clr = (n == clr_at);
            end
        end
        check("ready_within_bound", 32'(done), 32'd1);
        iomem_valid = 1'b0;
        s_ready     = 4'b0;
        err_clr     = 1'b0;
    endtask

    initial begin
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        s_ready     = 4'b0;
        err_clr     = 1'b0;
        s_rdata     = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h1234_5678};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;

        // read slot 0, slave ready 2 cycles after select
        access(32'h0300_0004, 4'b0000, 32'h0, 0, 2, 4'b0, 0, 32'h1234_5678, 4, 1'b0);
        // write slot 1, write still returns slave rdata
        access(32'h0400_0000, 4'b0011, 32'hCAFE_F00D, 1, 3, 4'b0, 0, 32'h1111_0001, 5, 1'b0);
        // top slot of the window, minimum latency
        access(32'h0600_0008, 4'b0000, 32'h0, 3, 0, 4'b0, 0, 32'h3333_0003, 2, 1'b0);
        // timeout on slot 2
        access(32'h0500_0010, 4'b0000, 32'h0, 2, -1, 4'b0, 0, 32'hDEAD_BEEF, 9, 1'b1);
        check("err_addr_t1", err_addr, 32'h0500_0010);

        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", 32'(err_flag), 32'h0);
        check("err_addr_kept", err_addr, 32'h0500_0010);

        // misses just above and below the window
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0700_0000;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) iomem_addr = 32'h0200_0000;
            @(negedge clk);
            check("miss_idle", {27'h0, iomem_ready, s_sel}, 32'h0);
        end
        iomem_valid = 1'b0;

        // s_ready[2] noise while slot 0 is selected
        access(32'h0300_0000, 4'b0000, 32'h0, 0, 3, 4'b0100, 0, 32'h1234_5678, 5, 1'b0);
        // ready on the timeout cycle wins
        access(32'h0500_0004, 4'b0000, 32'h0, 2, 7, 4'b0, 0, 32'h2222_0002, 9, 1'b0);
        // fresh timeout, then a timeout coincident with err_clr
        access(32'h0600_0020, 4'b0000, 32'h0, 3, -1, 4'b0, 0, 32'hDEAD_BEEF, 9, 1'b1);
        check("err_addr_t2", err_addr, 32'h0600_0020);
        access(32'h0400_0040, 4'b1111, 32'h5555_AAAA, 1, -1, 4'b0, 8, 32'hDEAD_BEEF, 9, 1'b1);
        check("err_addr_t3", err_addr, 32'h0400_0040);

        // reset while in ACCESS
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0100;
        iomem_wstrb = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_sel", 32'(s_sel), 32'h1);
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_ready_after_reset", 32'(iomem_ready), 32'h0);
        end
        access(32'h0300_0000, 4'b0000, 32'h0, 0, 1, 4'b0, 0, 32'h1234_5678, 3, 1'b0);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
